// File: rtl/alu_op_sequencer.sv
// ID/EX-boundary ALU operation decoder with RV32M support. Single-cycle codes are held
// behind a valid/ready handshake; M-extension codes wait out a per-class latency first.
module alu_op_sequencer #(
  parameter int OP_W    = 5,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 33,
  parameter bit M_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] operation,
  output logic            multi_cycle,
  output logic            unit_start,
  output logic            illegal
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SRL  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_XOR  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SRA  = 5'b00111;
  localparam logic [4:0] OP_SLT  = 5'b01011;
  localparam logic [4:0] OP_SLTU = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b01100;
  localparam logic [4:0] OP_BNE  = 5'b01101;
  localparam logic [4:0] OP_BLT  = 5'b01011;
  localparam logic [4:0] OP_BGE  = 5'b01010;
  localparam logic [4:0] OP_BLTU = 5'b01111;
  localparam logic [4:0] OP_BGEU = 5'b01110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam int               CNT_W   = 6;
  localparam logic [CNT_W-1:0] CNT_ONE = 6'd1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_BUSY = 2'b10,
    S_DONE = 2'b11
  } state_t;

  typedef struct packed {
    logic       ill;
    logic       m_op;
    logic       div_op;
    logic [4:0] code;
  } dec_t;

  // Register-register / immediate codes that share funct3 when funct7 is all zero.
  function automatic logic [4:0] base_code(input logic [2:0] f3);
    logic [4:0] c;
    case (f3)
      3'b000:  c = OP_ADD;
      3'b001:  c = OP_SLL;
      3'b010:  c = OP_SLT;
      3'b011:  c = OP_SLTU;
      3'b100:  c = OP_XOR;
      3'b101:  c = OP_SRL;
      3'b110:  c = OP_OR;
      3'b111:  c = OP_AND;
      default: c = OP_AND;
    endcase
    return c;
  endfunction

  function automatic dec_t decode(input logic [1:0] aop, input logic [6:0] f7,
                                  input logic [2:0] f3);
    dec_t d;
    d      = '0;
    d.code = OP_ADD;
    case (aop)
      2'b00: d.code = OP_ADD;
      2'b01: begin
        case (f3)
          3'b000:  d.code = OP_BEQ;
          3'b001:  d.code = OP_BNE;
          3'b100:  d.code = OP_BLT;
          3'b101:  d.code = OP_BGE;
          3'b110:  d.code = OP_BLTU;
          3'b111:  d.code = OP_BGEU;
          default: begin
            d.ill  = 1'b1;
            d.code = OP_AND;
          end
        endcase
      end
      2'b10: begin
        if (f7 == F7_BASE) begin
          d.code = base_code(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          d.code = OP_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          d.code = OP_SRA;
        end else if (f7 == F7_MEXT && M_EN == 1'b1) begin
          d.code   = {2'b10, f3};
          d.m_op   = 1'b1;
          d.div_op = f3[2];
        end else begin
          d.ill  = 1'b1;
          d.code = OP_AND;
        end
      end
      2'b11: begin
        // Immediates ignore funct7 except on shifts, where it selects/validates the shift kind.
        if (f3 == 3'b001 && f7 != F7_BASE) begin
          d.ill  = 1'b1;
          d.code = OP_AND;
        end else if (f3 == 3'b101 && f7 == F7_ALT) begin
          d.code = OP_SRA;
        end else if (f3 == 3'b101 && f7 != F7_BASE) begin
          d.ill  = 1'b1;
          d.code = OP_AND;
        end else begin
          d.code = base_code(f3);
        end
      end
      default: begin
        d.ill  = 1'b1;
        d.code = OP_AND;
      end
    endcase
    return d;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [OP_W-1:0]  operation_q, operation_d;
  logic             multi_cycle_q, multi_cycle_d;
  logic             unit_start_q, unit_start_d;
  logic             illegal_q, illegal_d;
  logic             in_ready_s;
  logic             accept_s;
  dec_t             dec_s;

  assign dec_s = decode(alu_op, funct7, funct3);

  // Ready follows out_ready while a result is held so a new request can swap in without a bubble.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_q)
      S_IDLE:         in_ready_s = 1'b1;
      S_HOLD, S_DONE: in_ready_s = out_ready;
      S_BUSY:         in_ready_s = 1'b0;
      default:        in_ready_s = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready_s & ~flush;

  // Next-state and registered-output computation; flush overrides any accept or progress.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    operation_d   = operation_q;
    multi_cycle_d = multi_cycle_q;
    illegal_d     = illegal_q;
    unit_start_d  = 1'b0;
    if (flush) begin
      state_d       = S_IDLE;
      cnt_d         = '0;
      out_valid_d   = 1'b0;
      operation_d   = '0;
      multi_cycle_d = 1'b0;
      illegal_d     = 1'b0;
    end else if (accept_s) begin
      operation_d   = OP_W'(dec_s.code);
      illegal_d     = dec_s.ill;
      multi_cycle_d = dec_s.m_op;
      if (dec_s.m_op) begin
        state_d      = S_BUSY;
        out_valid_d  = 1'b0;
        unit_start_d = 1'b1;
        cnt_d        = dec_s.div_op ? DIV_CNT : MUL_CNT;
      end else begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
        cnt_d       = '0;
      end
    end else begin
      case (state_q)
        S_BUSY: begin
          if (cnt_q == '0) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_HOLD, S_DONE: begin
          if (out_ready) begin
            state_d       = S_IDLE;
            out_valid_d   = 1'b0;
            operation_d   = '0;
            multi_cycle_d = 1'b0;
            illegal_d     = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        S_IDLE: state_d = S_IDLE;
        default: begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          out_valid_d   = 1'b0;
          operation_d   = '0;
          multi_cycle_d = 1'b0;
          illegal_d     = 1'b0;
        end
      endcase
    end
  end

  // State, latency counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      operation_q   <= '0;
      multi_cycle_q <= 1'b0;
      unit_start_q  <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      operation_q   <= operation_d;
      multi_cycle_q <= multi_cycle_d;
      unit_start_q  <= unit_start_d;
      illegal_q     <= illegal_d;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_q;
  assign operation   = operation_q;
  assign multi_cycle = multi_cycle_q;
  assign unit_start  = unit_start_q;
  assign illegal     = illegal_q;

endmodule
